// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared widths, opcode constants and the supported-opcode
// mask for the ALU issue stage.
// Ports: none (package).
package alu_issue_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned SEL_W  = 21;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned STAT_W = 32;

  // Opcode value k drives ALU select line k.
  localparam logic [OP_W-1:0] OP_ADD_0 = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB_0 = 5'd1;
  localparam logic [OP_W-1:0] OP_ADD_1 = 5'd4;
  localparam logic [OP_W-1:0] OP_ADD_2 = 5'd5;
  localparam logic [OP_W-1:0] OP_AND   = 5'd6;
  localparam logic [OP_W-1:0] OP_OR    = 5'd7;
  localparam logic [OP_W-1:0] OP_NAND  = 5'd8;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd9;
  localparam logic [OP_W-1:0] OP_ADD_3 = 5'd10;
  localparam logic [OP_W-1:0] OP_SUB_1 = 5'd11;
  localparam logic [OP_W-1:0] OP_SUB_2 = 5'd17;
  localparam logic [OP_W-1:0] OP_SUB_3 = 5'd18;

  // One bit per opcode value; set means the ALU implements it.
  localparam logic [31:0] SUPPORTED_MASK =
      (32'(1) << OP_ADD_0) | (32'(1) << OP_SUB_0) | (32'(1) << OP_ADD_1) |
      (32'(1) << OP_ADD_2) | (32'(1) << OP_AND)   | (32'(1) << OP_OR)    |
      (32'(1) << OP_NAND)  | (32'(1) << OP_XOR)   | (32'(1) << OP_ADD_3) |
      (32'(1) << OP_SUB_1) | (32'(1) << OP_SUB_2) | (32'(1) << OP_SUB_3);

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode decoder.
// Ports: op (opcode in), sel_c (one-hot ALU select, zero when unsupported),
//        err_c (opcode unsupported).
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] sel_c,
  output logic             err_c
);

  // Unsupported opcodes never drive any select line.
  always_comb begin
    err_c = ~SUPPORTED_MASK[op];
    sel_c = err_c ? '0 : (SEL_W'(1) << op);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage issue/result pipeline in front of an external
// combinational ALU. S1 holds the issued op and drives io_sel/io_alu1/io_alu2;
// S2 captures io_out and presents it on out_* with valid/ready handshake.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_op/in_alu1/
//        in_alu2/in_tag (upstream); io_sel/io_alu1/io_alu2/io_out (ALU);
//        out_valid/out_ready/out_result/out_tag/out_err (downstream);
//        stat_issued/stat_err (counters).
// Build option: define ALU_ISSUE_STATS_EN to implement the stat counters;
//        otherwise they read as zero.
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [XLEN-1:0]   in_alu1,
  input  logic [XLEN-1:0]   in_alu2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [SEL_W-1:0]  io_sel,
  output logic [XLEN-1:0]   io_alu1,
  output logic [XLEN-1:0]   io_alu2,
  input  logic [XLEN-1:0]   io_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic [STAT_W-1:0] stat_issued,
  output logic [STAT_W-1:0] stat_err
);

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_err;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_err;
  logic             s2_load;
  logic             accept;

  alu_op_decode u_decode (
    .op    (in_op),
    .sel_c (dec_sel),
    .err_c (dec_err)
  );

  // S2 takes S1 whenever S2 is empty or draining this cycle.
  assign s2_load  = s1_valid & (~out_valid | out_ready);
  // Reset term keeps in_ready high while reset is held.
  assign in_ready = reset | ~s1_valid | s2_load;
  assign accept   = in_valid & in_ready & ~reset;

  // S1: issue register driving the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      io_sel   <= '0;
      io_alu1  <= '0;
      io_alu2  <= '0;
      s1_tag   <= '0;
      s1_err   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      io_sel   <= dec_sel;
      io_alu1  <= in_alu1;
      io_alu2  <= in_alu2;
      s1_tag   <= in_tag;
      s1_err   <= dec_err;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
      io_sel   <= '0;
    end
  end

  // S2: result register; holds stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else if (s2_load) begin
      out_valid  <= 1'b1;
      out_result <= s1_err ? '0 : io_out;
      out_tag    <= s1_tag;
      out_err    <= s1_err;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [STAT_W-1:0] issued_q;
  logic [STAT_W-1:0] err_q;

  // Free-running counters, wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q <= '0;
      err_q    <= '0;
    end else if (accept) begin
      issued_q <= issued_q + STAT_W'(1);
      if (dec_err) err_q <= err_q + STAT_W'(1);
    end
  end

  assign stat_issued = issued_q;
  assign stat_err    = err_q;
`else
  assign stat_issued = '0;
  assign stat_err    = '0;
`endif

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 in_valid  in  1  upstream operation valid.
REQ-004 in_ready  out  1  stage accepts operation this cycle.
REQ-005 in_op  in  5  opcode; value k selects ALU select line k.
REQ-006 in_alu1  in  64  operand A.
REQ-007 in_alu2  in  64  operand B.
REQ-008 in_tag  in  4  destination tag, passed through unchanged.
REQ-009 io_sel  out  21  one-hot ALU select; bit k drives ALU io_sel_k.
REQ-010 io_alu1  out  64  registered operand A to ALU.
REQ-011 io_alu2  out  64  registered operand B to ALU.
REQ-012 io_out  in  64  combinational ALU result for current io_sel/io_alu1/io_alu2.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream accepts result.
REQ-015 out_result  out  64  captured ALU result.
REQ-016 out_tag  out  4  tag of out_result.
REQ-017 out_err  out  1  operation was unsupported opcode.
REQ-018 stat_issued  out  32  count of operations accepted into stage 1.
REQ-019 stat_err  out  32  count of unsupported operations accepted.

Function
REQ-020 Two register stages SHALL exist: S1 (issue: valid, sel, operands, tag, err) drives ALU; S2 (result: valid, result, tag, err) drives out_*.
REQ-021 Supported opcodes SHALL be: add {0,4,5,10}, sub {1,11,17,18}, and {6}, or {7}, nand {8}, xor {9}; io_sel SHALL be exactly bit in_op set.
REQ-022 Unsupported opcodes (2,3,12-16,19-31) SHALL load S1 with io_sel=0, err=1; S2 SHALL then capture result 0, not io_out.
REQ-023 io_sel SHALL be all-zero whenever S1 is invalid; io_alu1/io_alu2 SHALL hold last loaded values.
REQ-024 S2 load condition: S1 valid and (S2 empty or out_ready); S2 captures io_out (or 0 if err), tag, err.
REQ-025 in_ready SHALL equal (!S1 valid) or S2 load condition; combinational, no dependence on in_valid.
REQ-026 Accept (in_valid & in_ready) SHALL load S1; otherwise S1 clears valid when it moves to S2.
REQ-027 Latency accept-to-out_valid SHALL be 2 cycles; sustained throughput SHALL be 1 op/cycle with out_ready held high.
REQ-028 While out_valid & !out_ready, out_result/out_tag/out_err SHALL remain stable; S1 holds; in_ready=0 when S1 also full.
REQ-029 Simultaneous S2 drain and S2 reload in one cycle SHALL be lossless (no bubble, no duplicate).
REQ-030 Counters SHALL wrap modulo 2^32.

Reset
REQ-031 On reset: S1/S2 valid=0, io_sel=0, io_alu1=io_alu2=0, out_result=0, out_tag=0, out_err=0, counters=0; out_valid=0 from the cycle after reset is sampled.
REQ-032 Reset mid-operation SHALL discard in-flight operations with no output; in_ready SHALL read 1 during and after reset.

Configuration
REQ-033 Macro ALU_ISSUE_STATS_EN defined: stat_issued/stat_err counters implemented per REQ-018/019/030.
REQ-034 Macro ALU_ISSUE_STATS_EN undefined: no counter flops; stat_issued and stat_err tied to 0; ports still present.

Structure
REQ-035 Package alu_issue_pkg SHALL hold XLEN=64, SEL_W=21, TAG_W=4, OP_W=5, named opcode constants, and supported-opcode mask.
REQ-036 Sub-module alu_op_decode (combinational: in_op -> 21-bit one-hot sel, err) SHALL be instantiated once; the ALU itself is external.

Verification
REQ-037 op=0, A=5, B=7, tag=3, out_ready=1 -> io_sel=bit0 next cycle; out_valid, out_result=12, out_tag=3 two cycles after accept.
REQ-038 Back-to-back ops 1 (A=10,B=3), 8 (A=0xF0,B=0xFF), 9 (A=0xF,B=0x3) -> results 7, 0xFFFF_FFFF_FFFF_FF0F, 0xC on consecutive cycles.
REQ-039 op=14, A=B=1 -> io_sel=0, out_err=1, out_result=0; stat_err increments by 1 (with STATS_EN).
REQ-040 out_ready=0 for 4 cycles with 3 ops offered -> 2 held (S1,S2), in_ready=0, out_result stable; release -> all 3 delivered in order, none lost.
REQ-041 Reset asserted with S1 and S2 full -> next cycle out_valid=0, io_sel=0, in_ready=1, counters 0.
